// File: rtl/led_shift_out_if.sv
// LED shift-out bus: parallel pattern in, 595-style serial chain out.
// The master modport drives the pattern; the slave runs the chain.
interface led_shift_out_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] leds_in;
    logic             sclk;
    logic             sdata;
    logic             latch;
    logic             busy;
    logic             done;

    modport master (
        output leds_in,
        input  sclk, sdata, latch, busy, done
    );

    modport slave (
        input  leds_in,
        output sclk, sdata, latch, busy, done
    );
endinterface

// File: rtl/led_shift_out.sv
// Serialises changed LED patterns MSB-first into a 74HC595-style chain.
// Optional LED_SHIFT_PERIODIC_REFRESH_EN resends the pattern periodically.
module led_shift_out #(
    parameter int CLK_FREQ       = 25_000_000,
    parameter int SCLK_FREQ      = 1_000_000,
    parameter int WIDTH          = 8,
    parameter int REFRESH_CYCLES = 2_500_000
) (
    input logic             clk,
    input logic             rst_n,
    led_shift_out_if.slave  bus
);
    localparam int HALF_RAW = CLK_FREQ / (2 * SCLK_FREQ);
    localparam int HALF     = (HALF_RAW == 0) ? 1 : HALF_RAW;
    localparam int DW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BW       = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t           state, state_nx;
    logic [DW-1:0]    div, div_nx;
    logic [BW-1:0]    bit_cnt, bit_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [WIDTH-1:0] sent_reg, sent_nx;
    logic             force_tx, force_nx;
    logic             sclk_q, sclk_nx;
    logic             sdata_q, sdata_nx;
    logic             latch_q, latch_nx;
    logic             busy_q, busy_nx;
    logic             done_q, done_nx;
    logic             div_wrap;
    logic             start;

`ifdef LED_SHIFT_PERIODIC_REFRESH_EN
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    logic [RW-1:0] refresh_cnt, refresh_nx;
`endif

    assign div_wrap = (div == DW'(HALF - 1));
    assign start    = force_tx || (bus.leds_in != sent_reg);

    always_comb begin
        state_nx = state;
        div_nx   = div;
        bit_nx   = bit_cnt;
        shreg_nx = shreg;
        sent_nx  = sent_reg;
        force_nx = force_tx;
        sclk_nx  = sclk_q;
        sdata_nx = sdata_q;
        latch_nx = latch_q;
        busy_nx  = busy_q;
        done_nx  = 1'b0;
`ifdef LED_SHIFT_PERIODIC_REFRESH_EN
        refresh_nx = refresh_cnt;
`endif
        unique case (state)
            IDLE: begin
                sclk_nx  = 1'b0;
                latch_nx = 1'b0;
                busy_nx  = 1'b0;
                if (start) begin
                    shreg_nx = bus.leds_in;
                    sent_nx  = bus.leds_in;
                    force_nx = 1'b0;
                    sdata_nx = bus.leds_in[WIDTH-1];
                    busy_nx  = 1'b1;
                    div_nx   = '0;
                    bit_nx   = '0;
                    state_nx = SHIFT;
`ifdef LED_SHIFT_PERIODIC_REFRESH_EN
                    refresh_nx = '0;
                end else if (refresh_cnt == RW'(REFRESH_CYCLES - 1)) begin
                    force_nx   = 1'b1;
                    refresh_nx = '0;
                end else begin
                    refresh_nx = refresh_cnt + 1'b1;
`endif
                end
            end
            SHIFT: begin
                if (!div_wrap) begin
                    div_nx = div + 1'b1;
                end else begin
                    div_nx = '0;
                    if (!sclk_q) begin
                        sclk_nx = 1'b1;
                    end else begin
                        // falling edge: advance to the next bit
                        sclk_nx  = 1'b0;
                        shreg_nx = shreg << 1;
                        bit_nx   = bit_cnt + 1'b1;
                        if (bit_cnt == BW'(WIDTH - 1)) begin
                            sdata_nx = 1'b0;
                            latch_nx = 1'b1;
                            state_nx = LATCH;
                        end else begin
                            sdata_nx = shreg[WIDTH-2];
                        end
                    end
                end
            end
            LATCH: begin
                sclk_nx = 1'b0;
                if (!div_wrap) begin
                    div_nx = div + 1'b1;
                end else begin
                    div_nx   = '0;
                    latch_nx = 1'b0;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            sent_reg <= '0;
            force_tx <= 1'b1;
            sclk_q   <= 1'b0;
            sdata_q  <= 1'b0;
            latch_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            div      <= div_nx;
            bit_cnt  <= bit_nx;
            shreg    <= shreg_nx;
            sent_reg <= sent_nx;
            force_tx <= force_nx;
            sclk_q   <= sclk_nx;
            sdata_q  <= sdata_nx;
            latch_q  <= latch_nx;
            busy_q   <= busy_nx;
            done_q   <= done_nx;
        end
    end

`ifdef LED_SHIFT_PERIODIC_REFRESH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) refresh_cnt <= '0;
        else        refresh_cnt <= refresh_nx;
    end
`endif

    assign bus.sclk  = sclk_q;
    assign bus.sdata = sdata_q;
    assign bus.latch = latch_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_led_shift_out.sv
// Bench for led_shift_out: 595 chain model plus a transfer-level
// reference model predicting busy/done timing and latched words.
module tb_led_shift_out;
    localparam int W   = 8;
    localparam int H   = 2;
    localparam int BSY = 2 * W * H + H;
    localparam int RC  = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    led_shift_out_if #(.WIDTH(W)) bus ();

    led_shift_out #(
        .CLK_FREQ(8),
        .SCLK_FREQ(2),
        .WIDTH(W),
        .REFRESH_CYCLES(RC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // external 595 chain
    logic [W-1:0] sr595 = '0;
    logic [W-1:0] q595  = '0;
    int rises    = 0;
    int rx_count = 0;
    int lat_cyc  = 0;
    bit seen06   = 0;

    // transfer-level reference
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_sent = '0;
    bit m_force = 1'b1;
    bit m_done  = 1'b0;
    int m_cnt   = 0;
    int m_tx    = 0;
    int m_idle  = 0;

    always @(posedge bus.sclk) begin
        sr595 = {sr595[W-2:0], bus.sdata};
        rises++;
    end

    always @(posedge bus.latch) begin
        q595 = sr595;
        rx_count++;
        if (q595 == 8'h06) seen06 = 1'b1;
        check("sclk_pulses", rises, W);
        rises = 0;
        check("tx_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("word", q595, exp_q.pop_front());
    end

    always @(negedge clk) if (bus.latch) lat_cyc++;

    always @(negedge bus.latch) begin
        if (rst_n) check("latch_len", lat_cyc, H);
        lat_cyc = 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_force = 1'b1;
            m_done  = 1'b0;
            m_cnt   = 0;
            m_idle  = 0;
            m_sent  = '0;
            m_tx    = m_tx - exp_q.size();
            exp_q.delete();
            rises   = 0;
            lat_cyc = 0;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_done = 1'b1;
            end else if (m_force || bus.leds_in != m_sent) begin
                m_sent  = bus.leds_in;
                m_force = 1'b0;
                m_cnt   = BSY;
                m_idle  = 0;
                m_tx++;
                exp_q.push_back(bus.leds_in);
`ifdef LED_SHIFT_PERIODIC_REFRESH_EN
            end else if (m_idle == RC - 1) begin
                m_force = 1'b1;
                m_idle  = 0;
            end else begin
                m_idle++;
`endif
            end
        end
    end

    always @(negedge clk) begin
        check("busy", bus.busy, m_cnt > 0);
        check("done", bus.done, m_done);
    end

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_count < n && k < budget) begin
            step();
            k++;
        end
        check("rx_reached", rx_count >= n, 1);
    endtask

    initial begin
        bus.leds_in = '0;
        #1 rst_n = 1'b0;
        step();
        check("rst_sclk", bus.sclk, 0);
        check("rst_sdata", bus.sdata, 0);
        check("rst_latch", bus.latch, 0);
        check("rst_busy", bus.busy, 0);
        step();
        rst_n = 1'b1;

        // forced transfer after reset, then silence
        wait_rx(1, 100);
        check("first_word", q595, 8'h00);
        repeat (40) step();
        check("no_repeat", rx_count, 1);

        // single change
        bus.leds_in = 8'hA5;
        step();
        check("busy_rise", bus.busy, 1);
        wait_rx(2, 100);
        check("a5_word", q595, 8'hA5);

        // newest pattern wins
        bus.leds_in = 8'h01;
        repeat (5) step();
        bus.leds_in = 8'h06;
        repeat (5) step();
        bus.leds_in = 8'h07;
        wait_rx(4, 200);
        check("newest_word", q595, 8'h07);
        check("never_06", seen06, 0);

        // change then revert: nothing further
        bus.leds_in = 8'h0F;
        repeat (4) step();
        bus.leds_in = 8'h1F;
        repeat (3) step();
        bus.leds_in = 8'h0F;
        wait_rx(5, 200);
        repeat (50) step();
        check("revert_no_tx", rx_count, 5);
        check("revert_idle", bus.busy, 0);

        // reset mid-transfer
        bus.leds_in = 8'hFF;
        begin
            int k = 0;
            while (rises < 5 && k < 100) begin
                step();
                k++;
            end
            check("rise5_seen", rises >= 5, 1);
        end
        rst_n = 1'b0;
        #1;
        check("abort_sclk", bus.sclk, 0);
        check("abort_sdata", bus.sdata, 0);
        check("abort_latch", bus.latch, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        step();
        step();
        bus.leds_in = 8'h3C;
        rst_n = 1'b1;
        wait_rx(6, 100);
        check("post_rst_word", q595, 8'h3C);

        // random pattern traffic
        repeat (1500) begin
            step();
            if ($urandom_range(0, 15) == 0) bus.leds_in = W'($urandom);
        end
        begin
            int k = 0;
            while ((exp_q.size() > 0 || bus.busy) && k < 200) begin
                step();
                k++;
            end
        end
        check("queue_drained", exp_q.size(), 0);
        check("tx_total", rx_count, m_tx);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
